// File: rtl/operands.sv
// ---------------------------------------------------------------------------
// operands
//   Operand-stage select generator for an RV32I pipeline. Decodes the opcode
//   of the instruction in the operand stage to decide which register sources
//   it reads and how the ALU A/B inputs are sourced. It then compares those
//   sources against the destination of the instruction in memory/writeback
//   to choose writeback-forward data over register-file read data.
//
//   The block is purely combinational. clk is accepted for port compatibility
//   only. rst_n gates every output to 0 asynchronously.
//
// Ports
//   clk       in   1  system clock (no state is clocked from it)
//   rst_n     in   1  asynchronous active-low reset, forces all outputs to 0
//   opcode    in   7  instr[6:0] of the operand-stage instruction
//   rs1       in   5  source register 1 index
//   rs2       in   5  source register 2 index
//   rd_mw     in   5  destination index of the memory/writeback instruction
//   rwe_mw    in   1  register-write enable of the memory/writeback instruction
//   sel_rs1d  out  1  1 = rs1 from writeback-forward data, 0 = register file
//   sel_rs2d  out  1  1 = rs2 from writeback-forward data, 0 = register file
//   sel_a     out  1  ALU A select: 1 = PC, 0 = rs1 operand
//   sel_b     out  1  ALU B select: 1 = immediate, 0 = rs2 operand
// ---------------------------------------------------------------------------
module operands (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd_mw,
  input  logic       rwe_mw,
  output logic       sel_rs1d,
  output logic       sel_rs2d,
  output logic       sel_a,
  output logic       sel_b
);

  // RV32I major opcodes recognised by this stage.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // clk has no function here. Folding it into an unused net keeps the port
  // without leaving a dangling input.
  logic unused_clk;
  assign unused_clk = clk;

  // Per-opcode attributes.
  logic uses_rs1;
  logic uses_rs2;
  logic pc_to_a;
  logic imm_to_b;

  // Unrecognised opcodes fall through to the all-zero default. As a result,
  // no forwarding occurs and both ALU selects stay at 0.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    pc_to_a  = 1'b0;
    imm_to_b = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_I, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
        imm_to_b = 1'b1;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm_to_b = 1'b1;
      end
      // Branch target is computed as PC + imm in the ALU. The rs1/rs2
      // comparison happens in a separate comparator.
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        pc_to_a  = 1'b1;
        imm_to_b = 1'b1;
      end
      OP_JAL, OP_AUIPC: begin
        pc_to_a  = 1'b1;
        imm_to_b = 1'b1;
      end
      // LUI passes the immediate through B. A is a don't-care and is held at 0.
      OP_LUI: begin
        imm_to_b = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        pc_to_a  = 1'b0;
        imm_to_b = 1'b0;
      end
    endcase
  end

  // A writeback to x0 is architecturally discarded. It must never win over the
  // register file, whose x0 read is hard-wired to zero.
  logic wb_live;
  logic hit_rs1;
  logic hit_rs2;

  assign wb_live = rwe_mw & (rd_mw != 5'd0);
  assign hit_rs1 = uses_rs1 & wb_live & (rd_mw == rs1);
  assign hit_rs2 = uses_rs2 & wb_live & (rd_mw == rs2);

  // Reset gating is combinational, so assertion takes effect without a clock
  // edge. Release also shows the decoded values immediately.
  always_comb begin
    sel_rs1d = 1'b0;
    sel_rs2d = 1'b0;
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    if (rst_n) begin
      sel_rs1d = hit_rs1;
      sel_rs2d = hit_rs2;
      sel_a    = pc_to_a;
      sel_b    = imm_to_b;
    end
  end

endmodule

// File: tb/tb_operands.sv
// ---------------------------------------------------------------------------
// tb_operands
//   Self-checking bench for operands. Each vector is applied just after a
//   falling clk edge, and its expected select word is pushed to a scoreboard.
//   After 2 ns of settling (period 10 ns), the expected word is popped and
//   compared with {sel_rs1d, sel_rs2d, sel_a, sel_b}.
// ---------------------------------------------------------------------------
module tb_operands;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd_mw;
  logic       rwe_mw;
  logic       sel_rs1d;
  logic       sel_rs2d;
  logic       sel_a;
  logic       sel_b;

  operands dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd_mw    (rd_mw),
    .rwe_mw   (rwe_mw),
    .sel_rs1d (sel_rs1d),
    .sel_rs2d (sel_rs2d),
    .sel_a    (sel_a),
    .sel_b    (sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;

  logic [6:0] op_tab [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                             7'h6F, 7'h67, 7'h37, 7'h17};

  task automatic check_eq(input string tag, input logic [3:0] obs,
                          input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b (rs1d rs2d a b)", tag, obs, exp);
    end
  endtask

  // Reference table: {uses_rs1, uses_rs2, sel_a, sel_b} per opcode.
  function automatic logic [3:0] model(input logic [6:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d,
                                       input logic we, input logic rstn);
    logic [3:0] attr;
    logic       f1;
    logic       f2;
    case (op)
      7'h33:   attr = 4'b1100;
      7'h13:   attr = 4'b1001;
      7'h03:   attr = 4'b1001;
      7'h23:   attr = 4'b1101;
      7'h63:   attr = 4'b1111;
      7'h6F:   attr = 4'b0011;
      7'h67:   attr = 4'b1001;
      7'h37:   attr = 4'b0001;
      7'h17:   attr = 4'b0011;
      default: attr = 4'b0000;
    endcase
    f1 = attr[3] && we && (d != 5'd0) && (d == a);
    f2 = attr[2] && we && (d != 5'd0) && (d == b);
    if (!rstn) return 4'b0000;
    return {f1, f2, attr[1], attr[0]};
  endfunction

  task automatic check_head();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_empty: got none expected an entry");
      return;
    end
    e = sb_q.pop_front();
    check_eq(e.tag, {sel_rs1d, sel_rs2d, sel_a, sel_b}, e.exp);
  endtask

  task automatic apply(input string tag, input logic [6:0] op, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d, input logic we,
                       input logic [3:0] exp);
    @(negedge clk);
    opcode = op;
    rs1    = a;
    rs2    = b;
    rd_mw  = d;
    rwe_mw = we;
    sb_q.push_back('{tag, exp});
    #2;
    check_head();
  endtask

  initial begin
    logic [6:0] op;
    logic [4:0] a, b, d;
    logic       we;

    // Reset state with forwarding-heavy inputs present.
    rst_n  = 1'b0;
    opcode = 7'b0110011;
    rs1    = 5'd5;
    rs2    = 5'd5;
    rd_mw  = 5'd5;
    rwe_mw = 1'b1;
    sb_q.push_back('{"reset_state", 4'b0000});
    #2;
    check_head();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived results.
    apply("fwd_both",   7'b0110011, 5'd5, 5'd5, 5'd5, 1'b1, 4'b1100);
    apply("we_off",     7'b0100011, 5'd3, 5'd7, 5'd7, 1'b0, 4'b0001);
    apply("x0_dest",    7'b1100011, 5'd0, 5'd0, 5'd0, 1'b1, 4'b0011);
    apply("rs2_unused", 7'b0010011, 5'd9, 5'd9, 5'd9, 1'b1, 4'b1001);
    apply("jal_nosrc",  7'b1101111, 5'd4, 5'd4, 5'd4, 1'b1, 4'b0011);
    apply("store_rs2",  7'b0100011, 5'd3, 5'd7, 5'd7, 1'b1, 4'b0101);
    apply("branch_rs1", 7'b1100011, 5'd8, 5'd2, 5'd8, 1'b1, 4'b1011);
    apply("lui",        7'b0110111, 5'd6, 5'd6, 5'd6, 1'b1, 4'b0001);
    apply("auipc",      7'b0010111, 5'd6, 5'd6, 5'd6, 1'b1, 4'b0011);
    apply("jalr_rs1",   7'b1100111, 5'd31, 5'd1, 5'd31, 1'b1, 4'b1001);
    apply("load_miss",  7'b0000011, 5'd10, 5'd11, 5'd12, 1'b1, 4'b0001);

    // Asynchronous reset mid-stimulus, released away from any clk edge.
    apply("pre_reset",  7'b0110011, 5'd5, 5'd5, 5'd5, 1'b1, 4'b1100);
    rst_n = 1'b0;
    sb_q.push_back('{"async_reset", 4'b0000});
    #1;
    check_head();
    rst_n = 1'b1;
    sb_q.push_back('{"reset_release", 4'b1100});
    #1;
    check_head();

    apply("illegal_op", 7'b1111111, 5'd5, 5'd5, 5'd5, 1'b1, 4'b0000);
    apply("illegal_0",  7'b0000000, 5'd1, 5'd1, 5'd1, 1'b1, 4'b0000);

    // Sweep every legal opcode under live, x0 and disabled writebacks.
    for (int i = 0; i < 9; i++) begin
      apply("sweep_live", op_tab[i], 5'd6, 5'd6, 5'd6, 1'b1,
            model(op_tab[i], 5'd6, 5'd6, 5'd6, 1'b1, 1'b1));
      apply("sweep_x0",   op_tab[i], 5'd0, 5'd0, 5'd0, 1'b1,
            model(op_tab[i], 5'd0, 5'd0, 5'd0, 1'b1, 1'b1));
      apply("sweep_we0",  op_tab[i], 5'd6, 5'd6, 5'd6, 1'b0,
            model(op_tab[i], 5'd6, 5'd6, 5'd6, 1'b0, 1'b1));
    end

    // Random vectors. Indices are kept small so register matches are frequent.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) op = 7'($urandom);
      else                           op = op_tab[$urandom_range(0, 8)];
      a  = 5'($urandom_range(0, 3));
      b  = 5'($urandom_range(0, 3));
      d  = 5'($urandom_range(0, 3));
      we = 1'($urandom);
      apply("random", op, a, b, d, we, model(op, a, b, d, we, 1'b1));
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
